// File: rtl/pc_sequencer_if.sv
// Fetch-to-sequencer instruction handshake: decoded opcode and operand with valid/ready.
// Latency: wires only; no storage.
// Backpressure: the sequencer drops instr_ready whenever it cannot take an instruction.
interface pc_sequencer_if #(
    parameter int PC_WIDTH     = 8,
    parameter int OPCODE_WIDTH = 4
);
    logic                    instr_valid;
    logic                    instr_ready;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [PC_WIDTH-1:0]     operand;

    // Fetch side presents instructions and watches ready.
    modport master (
        output instr_valid,
        output opcode,
        output operand,
        input  instr_ready
    );

    // Sequencer side consumes instructions and drives ready.
    modport slave (
        input  instr_valid,
        input  opcode,
        input  operand,
        output instr_ready
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter / control-flow sequencer feeding the return stack; optional STACK_GUARD_EN adds a FAULT state.
// Latency: pc updates on the posedge of an accepted instruction; every taken transfer adds one FLUSH bubble.
// Backpressure: instr_ready is high only in RUN; FLUSH, HALT and FAULT all hold off fetch.
module pc_sequencer #(
    parameter int                         PC_WIDTH     = 8,
    parameter int                         OPCODE_WIDTH = 4,
    parameter logic [PC_WIDTH-1:0]        RESET_VECTOR = '0,
    parameter int                         STACK_DEPTH  = 16,
    parameter logic [OPCODE_WIDTH-1:0]    OP_NOP       = 4'd0,
    parameter logic [OPCODE_WIDTH-1:0]    OP_JMP       = 4'd1,
    parameter logic [OPCODE_WIDTH-1:0]    OP_CALL      = 4'd2,
    parameter logic [OPCODE_WIDTH-1:0]    OP_RET       = 4'd3,
    parameter logic [OPCODE_WIDTH-1:0]    OP_RESET     = 4'd4,
    parameter logic [OPCODE_WIDTH-1:0]    OP_HALT      = 4'd5
) (
    input  logic                    clock,
    input  logic                    reset,
    pc_sequencer_if.slave           fetch,
    input  logic                    resume,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [OPCODE_WIDTH-1:0] reset_code,
    output logic [PC_WIDTH-1:0]     called_from,
    input  logic [PC_WIDTH-1:0]     return_to,
    output logic                    halted,
    output logic                    fault
);

    // Depth must be able to hold the full value STACK_DEPTH (stack completely full).
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_FULL = DW'(STACK_DEPTH);
    localparam logic [DW-1:0] DEPTH_TOP  = DW'(STACK_DEPTH - 1);

`ifdef STACK_GUARD_EN
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2,
        S_FAULT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_HALT  = 2'd2
    } state_t;
`endif

    state_t               state;
    state_t               next_state;
    logic [PC_WIDTH-1:0]  next_pc;
    logic [DW-1:0]        depth;
    logic [DW-1:0]        next_depth;
    logic [DW-1:0]        depth_inc;
    logic [DW-1:0]        depth_dec;
    logic                 accept;

    assign fetch.instr_ready = (state == S_RUN);
    assign accept            = fetch.instr_valid && fetch.instr_ready;
    assign called_from       = pc;
    assign halted            = (state == S_HALT);

`ifdef STACK_GUARD_EN
    assign fault = (state == S_FAULT);
    // The guard blocks over/underflow, so plain increment/decrement stay in 0..STACK_DEPTH.
    assign depth_inc = depth + DW'(1);
    assign depth_dec = depth - DW'(1);
`else
    assign fault = 1'b0;
    // Without the guard the counter silently wraps modulo STACK_DEPTH, like the stack pointer.
    assign depth_inc = (depth >= DEPTH_TOP) ? '0 : depth + DW'(1);
    assign depth_dec = (depth == '0) ? DEPTH_TOP : depth - DW'(1);
`endif

    // State, pc and depth registers; reset returns straight to RUN at the reset vector.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            pc    <= RESET_VECTOR;
            depth <= '0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            depth <= next_depth;
        end
    end

    // Next-state, next-pc and stack opcode decode.
    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_depth = depth;
        reset_code = OP_NOP;

        unique case (state)
            S_RUN: begin
                if (accept) begin
                    if (fetch.opcode == OP_JMP) begin
                        next_pc    = fetch.operand;
                        next_state = S_FLUSH;
                    end else if (fetch.opcode == OP_CALL) begin
`ifdef STACK_GUARD_EN
                        if (depth == DEPTH_FULL) begin
                            // Overflowing CALL is swallowed: nothing reaches the stack, pc holds.
                            next_state = S_FAULT;
                        end else
`endif
                        begin
                            reset_code = OP_CALL;
                            next_pc    = fetch.operand;
                            next_depth = depth_inc;
                            next_state = S_FLUSH;
                        end
                    end else if (fetch.opcode == OP_RET) begin
`ifdef STACK_GUARD_EN
                        if (depth == '0) begin
                            // Underflowing RET is swallowed: nothing reaches the stack, pc holds.
                            next_state = S_FAULT;
                        end else
`endif
                        begin
                            reset_code = OP_RET;
                            next_pc    = return_to;
                            next_depth = depth_dec;
                            next_state = S_FLUSH;
                        end
                    end else if (fetch.opcode == OP_RESET) begin
                        reset_code = OP_RESET;
                        next_pc    = RESET_VECTOR;
                        next_depth = '0;
                        next_state = S_FLUSH;
                    end else if (fetch.opcode == OP_HALT) begin
                        next_state = S_HALT;
                    end else begin
                        // NOP and any unassigned encoding simply advance.
                        next_pc = pc + PC_WIDTH'(1);
                    end
                end
            end
            S_FLUSH: begin
                // Single bubble so fetch can drop the word it fetched down the old path.
                next_state = S_RUN;
            end
            S_HALT: begin
                if (resume) begin
                    next_pc    = pc + PC_WIDTH'(1);
                    next_state = S_RUN;
                end
            end
`ifdef STACK_GUARD_EN
            S_FAULT: begin
                // Sticky until reset.
                next_state = S_FAULT;
            end
`endif
            default: begin
                next_state = S_RUN;
            end
        endcase

        // Hold the stack cleared for as long as reset is asserted.
        if (reset) begin
            reset_code = OP_RESET;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then random traffic against a mode/queue model.
// Latency: model predicts comb outputs before each posedge and pc one posedge later.
// Backpressure: model decides ready from its own RUN/FLUSH/HALT/FAULT notion.
module tb_pc_sequencer;

    localparam logic [3:0] NOP   = 4'd0;
    localparam logic [3:0] JMP   = 4'd1;
    localparam logic [3:0] CALL  = 4'd2;
    localparam logic [3:0] RET   = 4'd3;
    localparam logic [3:0] RST   = 4'd4;
    localparam logic [3:0] HALT  = 4'd5;
    localparam int         DEPTH = 16;

    // Model modes (bench-private numbering).
    localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2, M_FAULT = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       resume = 1'b0;
    logic [7:0] return_to = 8'h00;
    logic [7:0] pc;
    logic [3:0] reset_code;
    logic [7:0] called_from;
    logic       halted;
    logic       fault;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int         m_mode;
    logic [7:0] m_pc;
    int         m_depth;
    logic [7:0] stk[$];

    pc_sequencer_if #(.PC_WIDTH(8), .OPCODE_WIDTH(4)) bus ();

    pc_sequencer #(
        .PC_WIDTH(8), .OPCODE_WIDTH(4), .RESET_VECTOR(8'h00), .STACK_DEPTH(DEPTH),
        .OP_NOP(NOP), .OP_JMP(JMP), .OP_CALL(CALL), .OP_RET(RET), .OP_RESET(RST), .OP_HALT(HALT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fetch(bus),
        .resume(resume),
        .pc(pc),
        .reset_code(reset_code),
        .called_from(called_from),
        .return_to(return_to),
        .halted(halted),
        .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_RUN;
        m_pc    = 8'h00;
        m_depth = 0;
        stk.delete();
    endtask

    // Synchronous-looking reset pulse; checks the values held while reset is high.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        resume = 1'b0;
        #1;
        model_reset();
        chk("rst_pc", pc, m_pc);
        chk("rst_code", reset_code, RST);
        chk("rst_halted", halted, 1'b0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_ready", bus.instr_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One clock of stimulus: drive at negedge, check comb outputs, clock, check pc.
    task automatic step(input logic v, input logic [3:0] op, input logic [7:0] opd,
                        input logic res, input logic [7:0] rt);
        logic       exp_ready;
        logic       acc;
        logic       trip;
        logic [3:0] exp_rc;
        logic [7:0] n_pc;
        int         n_mode;

        @(negedge clock);
        bus.instr_valid = v;
        bus.opcode      = op;
        bus.operand     = opd;
        resume          = res;
        return_to       = rt;
        #1;

        exp_ready = (m_mode == M_RUN);
        acc       = v && exp_ready;
        trip      = 1'b0;
`ifdef STACK_GUARD_EN
        trip = acc && ((op == CALL && m_depth == DEPTH) || (op == RET && m_depth == 0));
`endif
        exp_rc = NOP;
        if (acc && !trip && (op == CALL || op == RET || op == RST)) exp_rc = op;

        chk("ready", bus.instr_ready, exp_ready);
        chk("reset_code", reset_code, exp_rc);
        chk("called_from", called_from, m_pc);
        chk("halted", halted, m_mode == M_HALT);
        chk("fault", fault, m_mode == M_FAULT);

        n_pc   = m_pc;
        n_mode = m_mode;
        case (m_mode)
            M_RUN: if (acc) begin
                if (trip) n_mode = M_FAULT;
                else if (op == JMP) begin n_pc = opd; n_mode = M_FLUSH; end
                else if (op == CALL) begin
                    stk.push_back(m_pc + 8'd1);
                    if (stk.size() > DEPTH) void'(stk.pop_front());
                    m_depth = (m_depth + 1) % (DEPTH + 1);
                    n_pc = opd; n_mode = M_FLUSH;
                end else if (op == RET) begin
                    if (stk.size() > 0) void'(stk.pop_back());
                    m_depth = (m_depth == 0) ? DEPTH - 1 : m_depth - 1;
                    n_pc = rt; n_mode = M_FLUSH;
                end else if (op == RST) begin
                    stk.delete(); m_depth = 0;
                    n_pc = 8'h00; n_mode = M_FLUSH;
                end else if (op == HALT) n_mode = M_HALT;
                else n_pc = m_pc + 8'd1;
            end
            M_FLUSH: n_mode = M_RUN;
            M_HALT: if (res) begin n_pc = m_pc + 8'd1; n_mode = M_RUN; end
            default: n_mode = m_mode;
        endcase

        @(posedge clock);
        #1;
        m_pc   = n_pc;
        m_mode = n_mode;
        chk("pc", pc, m_pc);
    endtask

    function automatic logic [7:0] top_rt();
        return (stk.size() > 0) ? stk[$] : 8'($urandom);
    endfunction

    initial begin
        bus.instr_valid = 1'b0;
        bus.opcode      = NOP;
        bus.operand     = 8'h00;

        do_reset();

        // Stream of NOPs: pc 0 -> 1 -> 2 -> 3.
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        chk("nop_pc3", pc, 8'h03);

        // CALL from 0x10 to 0x40, then RET from 0x42 back to 0x11.
        step(1, JMP, 8'h10, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        chk("at_0x10", pc, 8'h10);
        step(1, CALL, 8'h40, 0, 8'h00);
        chk("call_pc", pc, 8'h40);
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        chk("at_0x42", pc, 8'h42);
        step(1, RET, 8'h00, 0, 8'h11);
        chk("ret_pc", pc, 8'h11);
        step(1, NOP, 8'h00, 0, 8'h00);

        // HALT at 0x05 for 10 cycles, then resume to 0x06.
        step(1, JMP, 8'h05, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, HALT, 8'h00, 0, 8'h00);
        for (int i = 0; i < 10; i++) step(1, NOP, 8'h00, 0, 8'h00);
        chk("halt_hold", halted, 1'b1);
        step(1, NOP, 8'h00, 1, 8'h00);
        chk("resume_pc", pc, 8'h06);

        // pc wrap 0xFF -> 0x00, and RESET opcode from 0x33.
        step(1, JMP, 8'hFF, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        chk("wrap_pc", pc, 8'h00);
        step(1, JMP, 8'h33, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, RST, 8'h00, 0, 8'h00);
        chk("reset_op_pc", pc, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);

        // Asynchronous reset in the middle of HALT returns immediately.
        step(1, JMP, 8'h20, 0, 8'h00);
        step(1, NOP, 8'h00, 0, 8'h00);
        step(1, HALT, 8'h00, 0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 8'h00);
        chk("async_halted", halted, 1'b0);
        chk("async_ready", bus.instr_ready, 1'b1);
        do_reset();
        step(1, NOP, 8'h00, 0, 8'h00);

`ifdef STACK_GUARD_EN
        // Overflow: 16 CALLs go through, the 17th faults with pc held.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            step(1, CALL, 8'h80, 0, 8'h00);
            step(0, NOP, 8'h00, 0, 8'h00);
        end
        step(1, CALL, 8'h90, 0, 8'h00);
        chk("ovf_fault", fault, 1'b1);
        chk("ovf_pc", pc, 8'h80);
        step(1, NOP, 8'h00, 1, 8'h00);
        // Underflow: RET straight after reset faults.
        do_reset();
        step(1, RET, 8'h00, 0, 8'h55);
        chk("udf_fault", fault, 1'b1);
        chk("udf_pc", pc, 8'h00);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), top_rt());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
